// File: rtl/shared_shift_pkg.sv
// Shared types and widths for the two-share nibble-rotation sequencer.
// Used by shared_shift_sequencer and shared_block_left_circular_shift_4bit.
package shared_shift_pkg;

    localparam int BLOCK_W = 64;
    localparam int HALF_W  = 32;
    localparam int ROT_W   = 4;
    localparam int AMT_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shared_block_left_circular_shift_4bit.sv
// Combinational 4-bit left rotation of each 32-bit half of two independent shares.
// The shares never interact; each half of each share is rotated on its own.
module shared_block_left_circular_shift_4bit
    import shared_shift_pkg::*;
(
    input  logic [63:0] in_share0,
    input  logic [63:0] in_share1,
    output logic [63:0] out_share0,
    output logic [63:0] out_share1
);

    genvar gi;
    generate
        for (gi = 0; gi < BLOCK_W / HALF_W; gi++) begin : g_half
            assign out_share0[gi*HALF_W +: HALF_W] =
                {in_share0[gi*HALF_W +: HALF_W-ROT_W], in_share0[gi*HALF_W+HALF_W-ROT_W +: ROT_W]};
            assign out_share1[gi*HALF_W +: HALF_W] =
                {in_share1[gi*HALF_W +: HALF_W-ROT_W], in_share1[gi*HALF_W+HALF_W-ROT_W +: ROT_W]};
        end
    endgenerate

endmodule

// File: rtl/shared_shift_sequencer.sv
// Multi-cycle sequencer rotating each 32-bit half of a 2-share block left by 4*amount bits.
// Define SHARED_SHIFT_REFRESH_EN to add refresh_mask, XORed into both shares on accept.
module shared_shift_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_amount,
    input  logic [63:0] in_share0,
    input  logic [63:0] in_share1,
`ifdef SHARED_SHIFT_REFRESH_EN
    input  logic [63:0] refresh_mask,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_share0,
    output logic [63:0] out_share1,
    output logic        busy
);
    import shared_shift_pkg::*;

    state_t             state_q, state_d;
    logic [BLOCK_W-1:0] share0_q, share0_d;
    logic [BLOCK_W-1:0] share1_q, share1_d;
    logic [AMT_W-1:0]   count_q, count_d;
    logic [BLOCK_W-1:0] rot_share0, rot_share1;
    logic [BLOCK_W-1:0] load_share0, load_share1;

    shared_block_left_circular_shift_4bit u_rot (
        .in_share0  (share0_q),
        .in_share1  (share1_q),
        .out_share0 (rot_share0),
        .out_share1 (rot_share1)
    );

`ifdef SHARED_SHIFT_REFRESH_EN
    // Same mask on both shares re-randomises them while keeping share0^share1 intact.
    assign load_share0 = in_share0 ^ refresh_mask;
    assign load_share1 = in_share1 ^ refresh_mask;
`else
    assign load_share0 = in_share0;
    assign load_share1 = in_share1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            share0_q <= '0;
            share1_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            share0_q <= share0_d;
            share1_q <= share1_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        share0_d = share0_q;
        share1_d = share1_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    share0_d = load_share0;
                    share1_d = load_share1;
                    count_d  = in_amount;
                    state_d  = (in_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                share0_d = rot_share0;
                share1_d = rot_share1;
                count_d  = count_q - 1'b1;
                if (count_q == 3'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Requests arriving here are dropped, so handoff always leaves a bubble.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    assign out_share0 = share0_q;
    assign out_share1 = share1_q;

endmodule

// File: tb/tb_shared_shift_sequencer.sv
// Randomized self-checking bench for shared_shift_sequencer against a rotate-by-4*amount model.
// Honours SHARED_SHIFT_REFRESH_EN when the design is built with it.
module tb_shared_shift_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_amount;
    logic [63:0] in_share0;
    logic [63:0] in_share1;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_share0;
    logic [63:0] out_share1;
    logic        busy;

`ifdef SHARED_SHIFT_REFRESH_EN
    logic [63:0] refresh_mask;
    localparam logic [63:0] MASK_ON = '1;
`else
    localparam logic [63:0] MASK_ON = '0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_out0;
    logic [63:0] last_out1;

    shared_shift_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_amount  (in_amount),
        .in_share0  (in_share0),
        .in_share1  (in_share1),
`ifdef SHARED_SHIFT_REFRESH_EN
        .refresh_mask (refresh_mask),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_share0 (out_share0),
        .out_share1 (out_share1),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference: rotate a 32-bit word left by 4*amt bits using plain shift arithmetic.
    function automatic logic [31:0] rot_word(input logic [31:0] x, input int amt);
        logic [63:0] t;
        t = {32'h0, x} << (4 * amt);
        return t[31:0] | t[63:32];
    endfunction

    function automatic logic [63:0] model_block(input logic [63:0] b, input int amt);
        return {rot_word(b[63:32], amt), rot_word(b[31:0], amt)};
    endfunction

    // One full request: accept, wait for result, hold in DONE, hand off.
    task automatic run_txn(input int amt, input logic [63:0] s0, input logic [63:0] s1,
                           input logic [63:0] m, input int hold, input bit keep_valid);
        int          lat;
        logic [63:0] em;
        logic [63:0] e0;
        logic [63:0] e1;
        em = m & MASK_ON;
        e0 = model_block(s0 ^ em, amt);
        e1 = model_block(s1 ^ em, amt);
        @(negedge clk);
        check_eq("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_amount = amt[2:0];
        in_share0 = s0;
        in_share1 = s1;
`ifdef SHARED_SHIFT_REFRESH_EN
        refresh_mask = m;
`endif
        out_ready = 1'b0;
        @(negedge clk);
        if (keep_valid) begin
            in_amount = 3'($urandom_range(0, 7));
            in_share0 = {$urandom, $urandom};
            in_share1 = {$urandom, $urandom};
        end else begin
            in_valid = 1'b0;
        end
        lat = 1;
        while (!out_valid && lat < 20) begin
            check_eq("busy_shift", busy, 1);
            check_eq("in_ready_shift", in_ready, 0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, amt + 1);
        check_eq("out_share0", out_share0, e0);
        check_eq("out_share1", out_share1, e1);
        check_eq("xor_invariant", out_share0 ^ out_share1, model_block(s0 ^ s1, amt));
        last_out0 = out_share0;
        last_out1 = out_share1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("done_hold_valid", out_valid, 1);
            check_eq("done_hold_ready", in_ready, 0);
            check_eq("done_hold_s0", out_share0, e0);
            check_eq("done_hold_s1", out_share1, e1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check_eq("post_handoff_valid", out_valid, 0);
        check_eq("post_handoff_ready", in_ready, 1);
        check_eq("post_handoff_busy", busy, 0);
        $display("txn amt=%0d s0=%h s1=%h lat=%0d out0=%h out1=%h", amt, s0, s1, lat, last_out0, last_out1);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_out_share0"}, out_share0, 64'h0);
        check_eq({tag, "_out_share1"}, out_share1, 64'h0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_amount = '0;
        in_share0 = '0;
        in_share1 = '0;
        out_ready = 1'b0;
`ifdef SHARED_SHIFT_REFRESH_EN
        refresh_mask = '0;
`endif
        repeat (2) @(negedge clk);
        check_reset_state("reset");

        // Reset wins over a simultaneous accept.
        in_valid  = 1'b1;
        in_amount = 3'd3;
        in_share0 = 64'hDEADBEEF_CAFEF00D;
        in_share1 = 64'h12345678_9ABCDEF0;
        @(negedge clk);
        check_reset_state("reset_vs_accept");
        in_valid = 1'b0;
        rst      = 1'b0;

        run_txn(1, 64'h01234567_89ABCDEF, 64'hFFFF0000_0000FFFF, 64'h0, 0, 0);
        run_txn(0, 64'h13579BDF_2468ACE0, 64'h0F0F0F0F_F0F0F0F0, 64'h0, 1, 0);
        run_txn(7, 64'h01234567_89ABCDEF, 64'h00000000_00000000, 64'h0, 0, 0);
        run_txn(3, 64'hAAAA5555_33CC33CC, 64'h8000_0001_7FFF_FFFE, 64'h0, 5, 1);

`ifndef SHARED_SHIFT_REFRESH_EN
        run_txn(1, 64'h01234567_89ABCDEF, 64'hFFFF0000_0000FFFF, 64'h0, 0, 0);
        check_eq("vec_amt1_s0", last_out0, 64'h12345670_9ABCDEF8);
        check_eq("vec_amt1_s1", last_out1, 64'hFFF0000F_000FFFF0);
        run_txn(7, 64'h01234567_89ABCDEF, 64'h0, 64'h0, 0, 0);
        check_eq("vec_amt7_s0", last_out0, 64'h70123456_F89ABCDE);
`else
        run_txn(2, 64'h01234567_89ABCDEF, 64'hFFFF0000_0000FFFF, 64'hA5A5A5A5_5A5A5A5A, 0, 0);
        check_eq("refresh_s0_differs", last_out0 != model_block(64'h01234567_89ABCDEF, 2), 1);
`endif

        // Reset during the second SHIFT cycle of an amount-5 request.
        @(negedge clk);
        in_valid  = 1'b1;
        in_amount = 3'd5;
        in_share0 = 64'h0BADC0DE_FEEDFACE;
        in_share1 = 64'h11112222_33334444;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("abort_shift1_busy", busy, 1);
        @(negedge clk);
        check_eq("abort_shift2_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("abort");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("abort_no_result", out_valid, 0);
        end
        run_txn(5, 64'h0BADC0DE_FEEDFACE, 64'h11112222_33334444, 64'h0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            run_txn(int'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_shift_sequencer.md
SHARED_SHIFT_SEQUENCER -- requirements
Module: shared_shift_sequencer

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed: 64-bit block, two 32-bit halves, 3-bit amount.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request carries a 2-share block and an amount.
REQ-005 in_ready  output  1  block accepts a request; accept = in_valid & in_ready.
REQ-006 in_amount  input  3  number of 4-bit left rotations per 32-bit half, 0..7.
REQ-007 in_share0 / in_share1  input  64 each  share 0 / share 1 of the block.
REQ-008 refresh_mask  input  64  fresh randomness; present only with SHARED_SHIFT_REFRESH_EN.
REQ-009 out_valid  output  1  result shares are valid.
REQ-010 out_ready  input  1  consumer takes result; handoff = out_valid & out_ready.
REQ-011 out_share0 / out_share1  output  64 each  rotated shares.
REQ-012 busy  output  1  high in SHIFT or DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 On accept, both share registers SHALL load, the remaining-count register SHALL load in_amount, and the next state SHALL be SHIFT if in_amount!=0, else DONE.
REQ-016 In SHIFT, each cycle SHALL rotate each 32-bit half of both shares left by 4 bits and decrement the count; leaving for DONE on the cycle the count goes 1->0.
REQ-017 Latency from accept to out_valid SHALL be in_amount+1 cycles; amount 0 gives 1 cycle with data unchanged.
REQ-018 Shares SHALL be processed independently; the two shares are never combined (no XOR, AND or mux between share 0 and share 1).
REQ-019 In DONE, outputs SHALL hold stable until handoff; handoff returns to IDLE next cycle.
REQ-020 in_valid during SHIFT/DONE SHALL be ignored (not accepted, not queued); a simultaneous handoff and in_valid in DONE accepts nothing, giving a one-cycle bubble.
REQ-021 out_share0/out_share1 SHALL be driven directly from the share registers, stable from out_valid rise to handoff.

Reset
REQ-022 When rst is high at a clock edge, state SHALL become IDLE, share and count registers zero, out_valid 0, busy 0, in_ready 1 from the following cycle.
REQ-023 Reset SHALL abort any SHIFT or DONE transaction with no result emitted; rst has priority over accept and handoff in the same cycle.

Configuration
REQ-024 With macro SHARED_SHIFT_REFRESH_EN defined, port refresh_mask SHALL exist and, on accept, both shares SHALL load XORed with refresh_mask (share0^mask, share1^mask), preserving share0^share1.
REQ-025 Without SHARED_SHIFT_REFRESH_EN, refresh_mask SHALL be absent and shares SHALL load unmodified.

Structure
REQ-026 Package shared_shift_pkg SHALL hold the state enum (IDLE, SHIFT, DONE), BLOCK_W=64, HALF_W=32, ROT_W=4, AMT_W=3.
REQ-027 The per-cycle rotation SHALL be one instance of the existing combinational shared_block_left_circular_shift_4bit, fed by the share registers; no other sub-modules.

Verification
REQ-028 Amount 1, share0=64'h01234567_89ABCDEF, share1=64'hFFFF0000_0000FFFF -> after 2 cycles out_share0=64'h12345670_9ABCDEF8, out_share1=64'hFFF0000F_000FFFF0.
REQ-029 Amount 0, any shares -> out_valid one cycle after accept, outputs equal inputs; amount 7 on share0=64'h01234567_89ABCDEF -> out_share0=64'h70123456_F89ABCDE after 8 cycles.
REQ-030 out_ready held low 5 cycles in DONE with in_valid high -> outputs stable, in_ready 0, no second accept; out_ready=1 -> IDLE next cycle, then the pending request is accepted.
REQ-031 rst asserted on the 2nd SHIFT cycle of an amount-5 request -> next cycle state IDLE, out_valid 0, outputs 0, no result emitted; a new request then completes normally.
REQ-032 With SHARED_SHIFT_REFRESH_EN, mask=64'hA5A5A5A5_5A5A5A5A, amount 2 -> out_share0^out_share1 equals the unmasked amount-2 rotation of in_share0^in_share1, and out_share0 differs from the unmasked result.
